// File: rtl/systolic_pkg.sv
// Shared types and lane-delay helpers for the systolic array edge stagers.
package systolic_pkg;

  typedef enum logic {SKEW = 1'b0, DESKEW = 1'b1} skew_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stager_state_e;

  function automatic int unsigned lane_delay(input int unsigned k, input int unsigned n,
                                             input skew_mode_e mode, input bit reg_out);
    int unsigned base;
    base = (mode == SKEW) ? k : (n - 1 - k);
    return base + {31'd0, reg_out};
  endfunction

  // Deepest tap a lane can ever select across both modes.
  function automatic int unsigned lane_max_depth(input int unsigned k, input int unsigned n,
                                                 input bit reg_out);
    int unsigned a;
    int unsigned b;
    a = k;
    b = n - 1 - k;
    return ((a > b) ? a : b) + {31'd0, reg_out};
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the stager: a stallable {valid, data} shift chain with a runtime tap.
module skew_delay_line #(
  parameter int MAX_DEPTH = 1,
  parameter int DATA_W    = 16,
  localparam int SEL_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic [SEL_W-1:0]  tap_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [MAX_DEPTH-1:0]             vld_q;
  logic [MAX_DEPTH-1:0][DATA_W-1:0] dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (!stall_i) begin
      vld_q[0] <= valid_i;
      dat_q[0] <= valid_i ? data_i : '0;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Tap 0 is the combinational bypass; it goes quiet while stalled.
  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    if (tap_i == '0) begin
      valid_o = valid_i & ~stall_i;
      data_o  = (valid_i & ~stall_i) ? data_i : '0;
    end else begin
      for (int i = 1; i <= MAX_DEPTH; i++) begin
        if (int'(tap_i) == i) begin
          valid_o = vld_q[i-1];
          data_o  = dat_q[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_skew_stager.sv
// Per-lane skew/de-skew stage feeding or draining the systolic MAC array.
module systolic_skew_stager
  import systolic_pkg::*;
#(
  parameter int N       = 32,
  parameter int DATA_W  = 16,
  parameter int REG_OUT = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       read_i,
  input  logic                       last_i,
  input  logic                       stall_i,
  input  logic                       mode_i,
  input  logic [N-1:0][DATA_W-1:0]   data_i,
  output logic [N-1:0][DATA_W-1:0]   data_o,
  output logic [N-1:0]               valid_o,
  output logic                       act_data_rdy_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int D     = N - 1 + REG_OUT;
  localparam int CNT_W = $clog2(N + 1);

  // Handshake: read_i is the valid, !stall_i is the ready; a vector moves only when both hold.
  logic accept;
  assign accept = read_i & ~stall_i;

  stager_state_e    state_q, state_d;
  skew_mode_e       mode_q, mode_d, mode_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A tile accepted from IDLE must already use its own mode for the zero-delay lane.
  assign mode_eff = (state_q == IDLE && accept) ? skew_mode_e'(mode_i) : mode_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (!stall_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (accept && last_i) cnt_d = CNT_W'(D);
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_d  = mode_eff;
            state_d = last_i ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept && last_i) state_d = DRAIN;
        end
        DRAIN: begin
          if (accept) state_d = last_i ? DRAIN : RUN;
          else if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= SKEW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // A follow-on tile leaving DRAIN for RUN retires the pending done; only the final tile reports.
  assign done_o         = (state_q == DRAIN) && (cnt_q == CNT_W'(1)) && !stall_i;
  assign busy_o         = (state_q != IDLE);
  assign act_data_rdy_o = |valid_o;

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int DEPTH = int'(lane_max_depth(k, N, REG_OUT != 0));
    localparam int SEL_W = $clog2(DEPTH + 1);
    logic [SEL_W-1:0] tap;
    assign tap = SEL_W'(lane_delay(k, N, mode_eff, REG_OUT != 0));

    skew_delay_line #(
      .MAX_DEPTH(DEPTH),
      .DATA_W   (DATA_W)
    ) u_line (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .stall_i(stall_i),
      .tap_i  (tap),
      .valid_i(accept),
      .data_i (data_i[k]),
      .valid_o(valid_o[k]),
      .data_o (data_o[k])
    );
  end

endmodule

// File: tb/tb_systolic_skew_stager.sv
// Bench for systolic_skew_stager: REG_OUT=0 and REG_OUT=1 instances driven in lockstep.
module tb_systolic_skew_stager;

  localparam int N  = 4;
  localparam int DW = 16;
  typedef logic [N-1:0][DW-1:0] vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, read, last, stall, mode;
  vec_t data_in;
  vec_t data_o0, data_o1;
  logic [N-1:0] valid0, valid1;
  logic rdy0, rdy1, busy0, busy1, done0, done1;

  systolic_skew_stager #(.N(N), .DATA_W(DW), .REG_OUT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .read_i(read), .last_i(last), .stall_i(stall),
    .mode_i(mode), .data_i(data_in), .data_o(data_o0), .valid_o(valid0),
    .act_data_rdy_o(rdy0), .busy_o(busy0), .done_o(done0)
  );

  systolic_skew_stager #(.N(N), .DATA_W(DW), .REG_OUT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .read_i(read), .last_i(last), .stall_i(stall),
    .mode_i(mode), .data_i(data_in), .data_o(data_o1), .valid_o(valid1),
    .act_data_rdy_o(rdy1), .busy_o(busy1), .done_o(done1)
  );

  // scoreboard: {dut[31], cycles_left[30:24], lane[23:16], data[15:0]}
  logic [31:0] exp_q[$];
  int   pend[2];
  logic busy_m[2];
  logic mode_m[2];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  function automatic int dly(input int k, input logic m, input int r);
    return (m ? (N - 1 - k) : k) + r;
  endfunction

  function automatic vec_t mkvec(input logic [DW-1:0] l3, input logic [DW-1:0] l2,
                                 input logic [DW-1:0] l1, input logic [DW-1:0] l0);
    vec_t v;
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    return v;
  endfunction

  function automatic vec_t rndvec();
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = DW'($urandom_range(1, 16'hffff));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, checks, and model update
  task automatic step(input logic r_read, input logic r_last, input logic r_stall,
                      input logic r_mode, input vec_t r_data, input logic r_rst);
    logic        acc;
    vec_t        ev[2];
    logic [N-1:0] vv[2];
    logic        done_now;
    logic [31:0] nq[$];
    @(posedge clk);
    #1;
    read = r_read; last = r_last; stall = r_stall; mode = r_mode;
    data_in = r_data; rst = r_rst;
    acc = r_read & ~r_stall;
    if (acc) begin
      for (int u = 0; u < 2; u++) begin
        if (!busy_m[u]) mode_m[u] = r_mode;
        for (int k = 0; k < N; k++)
          exp_q.push_back({1'(u), 7'(dly(k, mode_m[u], u)), 8'(k), r_data[k]});
      end
    end
    #3;
    for (int u = 0; u < 2; u++) begin
      ev[u] = '0;
      vv[u] = '0;
    end
    foreach (exp_q[i]) begin
      if (exp_q[i][30:24] == 7'd0) begin
        ev[exp_q[i][31]][exp_q[i][23:16]] = exp_q[i][15:0];
        vv[exp_q[i][31]][exp_q[i][23:16]] = 1'b1;
      end
    end
    check("data_r0",  64'(data_o0), 64'(ev[0]));
    check("valid_r0", 64'(valid0),  64'(vv[0]));
    check("rdy_r0",   64'(rdy0),    64'(|vv[0]));
    check("busy_r0",  64'(busy0),   64'(busy_m[0]));
    check("done_r0",  64'(done0),   64'(pend[0] == 1 && !r_stall));
    check("data_r1",  64'(data_o1), 64'(ev[1]));
    check("valid_r1", 64'(valid1),  64'(vv[1]));
    check("rdy_r1",   64'(rdy1),    64'(|vv[1]));
    check("busy_r1",  64'(busy1),   64'(busy_m[1]));
    check("done_r1",  64'(done1),   64'(pend[1] == 1 && !r_stall));
    if (r_rst) begin
      exp_q = {};
      for (int u = 0; u < 2; u++) begin
        pend[u] = 0; busy_m[u] = 1'b0; mode_m[u] = 1'b0;
      end
    end else if (!r_stall) begin
      nq = {};
      foreach (exp_q[i])
        if (exp_q[i][30:24] != 7'd0)
          nq.push_back({exp_q[i][31], exp_q[i][30:24] - 7'd1, exp_q[i][23:0]});
      exp_q = nq;
      for (int u = 0; u < 2; u++) begin
        done_now = (pend[u] == 1);
        if (pend[u] > 0) pend[u]--;
        if (acc && r_last) pend[u] = N - 1 + u;
        else if (acc) pend[u] = 0;
        if (acc) busy_m[u] = 1'b1;
        else if (done_now) busy_m[u] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; read = 1'b0; last = 1'b0; stall = 1'b0; mode = 1'b0; data_in = '0;
    for (int u = 0; u < 2; u++) begin
      pend[u] = 0; busy_m[u] = 1'b0; mode_m[u] = 1'b0;
    end
    v = mkvec(16'h0044, 16'h0033, 16'h0022, 16'h0011);

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);

    // single-vector tile, SKEW
    step(1'b1, 1'b1, 1'b0, 1'b0, v, 1'b0);
    idle(7);

    // single-vector tile, DESKEW
    step(1'b1, 1'b1, 1'b0, 1'b1, v, 1'b0);
    idle(7);

    // back-to-back tiles of three vectors each
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 3; i++) step(1'b1, 1'(i == 2), 1'b0, 1'b0, rndvec(), 1'b0);
    idle(7);

    // stall for two cycles right after a last accept, read held high meanwhile
    step(1'b1, 1'b1, 1'b0, 1'b0, v, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, v, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, v, 1'b0);
    idle(7);

    // mode toggled while running, then a fresh tile from IDLE in DESKEW
    step(1'b1, 1'b0, 1'b0, 1'b0, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    idle(7);
    step(1'b1, 1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    idle(7);

    // reset in the middle of a DESKEW tile, then a SKEW tile
    step(1'b1, 1'b0, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, rndvec(), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, v, 1'b0);
    idle(7);

    // random traffic with stalls, tile boundaries and mode requests
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), rndvec(), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, rndvec(), 1'b0);
    idle(8);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
